ram_rr_ctrl: RTL and testbench

- Two-port round-robin controller that shares one single-port RAM (cs/we/oe/addr/data_in/data_out) between two requesters (m0, m1).
- Each requester has a valid/ready request channel and a one-cycle read-response pulse.
- Sits between requesting logic and the single-port RAM. It is the only driver of the RAM control pins.

---
 rtl/ram_pkg.sv | 16 +
 rtl/ram_rr_ctrl_if.sv | 23 ++
 rtl/rr_arb2.sv | 39 +++
 rtl/ram_rr_ctrl.sv | 134 +++++++++++++
 tb/tb_ram_rr_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared constants and types for the round-robin single-port RAM controller.
package ram_pkg;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} ram_ctrl_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
  } ram_req_t;

endpackage

// File: rtl/ram_rr_ctrl_if.sv
// Requester channel: valid/ready request plus one-cycle read-response pulse.
interface ram_rr_ctrl_if;
  import ram_pkg::*;

  logic              valid;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  wdata;
  logic              ready;
  logic              rvalid;
  logic [WIDTH-1:0]  rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-granted requester drops to lowest priority.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // prio_q = 0: requester 0 wins a tie, 1: requester 1 wins a tie
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    prio_d = prio_q;
    if (advance && (|gnt)) begin
      prio_d = gnt[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/ram_rr_ctrl.sv
// Shares one single-port RAM between two requesters with round-robin arbitration.
module ram_rr_ctrl
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  ram_rr_ctrl_if.slave      m0,
  ram_rr_ctrl_if.slave      m1,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_data_in,
  input  logic [WIDTH-1:0]  ram_data_out
);

  ram_ctrl_state_e  state_q, state_d;
  ram_req_t         req_q, req_d;
  logic             gnt_sel_q, gnt_sel_d;
  logic             ram_cs_q, ram_cs_d;
  logic             ram_we_q, ram_we_d;
  logic             ram_oe_q, ram_oe_d;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;
  logic [WIDTH-1:0] rdata0_q, rdata0_d;
  logic [WIDTH-1:0] rdata1_q, rdata1_d;
  logic [1:0]       gnt;
  logic             accept;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({m1.valid, m0.valid}),
    .advance (accept),
    .gnt     (gnt)
  );

  assign accept   = (state_q == IDLE) && (|gnt);
  assign m0.ready = rst_n && accept && gnt[0];
  assign m1.ready = rst_n && accept && gnt[1];

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = req_q.we ? IDLE : WAIT;
      WAIT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // output logic: registered RAM pins follow the state being entered
  always_comb begin
    req_d     = req_q;
    gnt_sel_d = gnt_sel_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;

    if (accept) begin
      gnt_sel_d = gnt[1];
      if (gnt[1]) begin
        req_d.we    = m1.we;
        req_d.addr  = m1.addr;
        req_d.wdata = m1.wdata;
      end else begin
        req_d.we    = m0.we;
        req_d.addr  = m0.addr;
        req_d.wdata = m0.wdata;
      end
    end

    ram_cs_d  = (state_d == ISSUE);
    ram_we_d  = ram_cs_d && req_d.we;
    ram_oe_d  = (ram_cs_d && !req_d.we) || (state_d == WAIT);
    rvalid0_d = (state_d == RESP) && !gnt_sel_d;
    rvalid1_d = (state_d == RESP) && gnt_sel_d;

    // RAM read data is valid during WAIT
    if (state_q == WAIT) begin
      if (gnt_sel_q) begin
        rdata1_d = ram_data_out;
      end else begin
        rdata0_d = ram_data_out;
      end
    end
  end

  // output and request-latch registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q     <= '0;
      gnt_sel_q <= 1'b0;
      ram_cs_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      ram_oe_q  <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      req_q     <= req_d;
      gnt_sel_q <= gnt_sel_d;
      ram_cs_q  <= ram_cs_d;
      ram_we_q  <= ram_we_d;
      ram_oe_q  <= ram_oe_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign ram_cs      = ram_cs_q;
  assign ram_we      = ram_we_q;
  assign ram_oe      = ram_oe_q;
  assign ram_addr    = req_q.addr;
  assign ram_data_in = req_q.wdata;
  assign m0.rvalid   = rvalid0_q;
  assign m0.rdata    = rdata0_q;
  assign m1.rvalid   = rvalid1_q;
  assign m1.rdata    = rdata1_q;

endmodule

// File: tb/tb_ram_rr_ctrl.sv
// Bench for ram_rr_ctrl: directed and random traffic against a transaction-level reference model.
module tb_ram_rr_ctrl;
  import ram_pkg::*;

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              ram_cs, ram_we, ram_oe;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_data_in;
  logic [WIDTH-1:0]  ram_data_out;

  ram_rr_ctrl_if m0 ();
  ram_rr_ctrl_if m1 ();

  ram_rr_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0           (m0),
    .m1           (m1),
    .ram_cs       (ram_cs),
    .ram_we       (ram_we),
    .ram_oe       (ram_oe),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port RAM attached to the controller
  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [WIDTH-1:0] ram_dout = '0;
  assign ram_data_out = ram_dout;

  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_data_in;
    else if (ram_cs && ram_oe) ram_dout <= mem[ram_addr];
  end

  // Reference model state
  logic [WIDTH-1:0] ref_mem [DEPTH] = '{default: '0};
  ram_req_t pend0[$], pend1[$];
  exp_t     exp0[$], exp1[$];
  int       grant_log[$];
  bit       ref_prio;
  int       busy_until, rd_iss, iss_cyc;
  ram_req_t iss_req;
  bit       iss_pend, rst_seen, hold0, hold1;
  int       cycle, n_pass, n_checks, base;
  int       exp_order [4] = '{0, 1, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cycle);
  endtask

  function automatic ram_req_t mk_req(input logic we, input int addr, input int data);
    ram_req_t r;
    r.we    = we;
    r.addr  = ADDR_W'(addr);
    r.wdata = WIDTH'(data);
    return r;
  endfunction

  function automatic ram_req_t rnd_req();
    return mk_req(1'($urandom_range(1)), int'($urandom_range(DEPTH - 1)), int'($urandom_range(255)));
  endfunction

  task automatic drive();
    m0.valid = (pend0.size() != 0);
    if (pend0.size() != 0) begin
      m0.we = pend0[0].we; m0.addr = pend0[0].addr; m0.wdata = pend0[0].wdata;
    end
    m1.valid = (pend1.size() != 0);
    if (pend1.size() != 0) begin
      m1.we = pend1[0].we; m1.addr = pend1[0].addr; m1.wdata = pend1[0].wdata;
    end
  endtask

  // One clock: observe and check at negedge, then advance the model and drivers after posedge
  task automatic step();
    bit g0, g1, want, win, issue_now, rv0, rv1;
    ram_req_t r;
    exp_t e;
    g0 = 1'b0;
    g1 = 1'b0;
    @(negedge clk);
    if (hold0) chk("m0_valid_held", 32'(m0.valid), 32'd1);
    if (hold1) chk("m1_valid_held", 32'(m1.valid), 32'd1);
    if (!rst_n) begin
      chk("rst_m0_ready", 32'(m0.ready), 32'd0);
      chk("rst_m1_ready", 32'(m1.ready), 32'd0);
      if (rst_seen) begin
        chk("rst_ram_cs", 32'(ram_cs), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_oe", 32'(ram_oe), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_data_in", 32'(ram_data_in), 32'd0);
        chk("rst_m0_rvalid", 32'(m0.rvalid), 32'd0);
        chk("rst_m1_rvalid", 32'(m1.rvalid), 32'd0);
        chk("rst_m0_rdata", 32'(m0.rdata), 32'd0);
        chk("rst_m1_rdata", 32'(m1.rdata), 32'd0);
      end
    end else begin
      g0   = m0.valid && m0.ready;
      g1   = m1.valid && m1.ready;
      want = (m0.valid || m1.valid) && (cycle >= busy_until);
      chk("accept", 32'(g0 || g1), 32'(want));
      chk("ready_exclusive", 32'(m0.ready && m1.ready), 32'd0);
      if (want) begin
        win = (m0.valid && m1.valid) ? ref_prio : m1.valid;
        chk("grant_port", 32'(g1), 32'(win));
        r = win ? pend1[0] : pend0[0];
        ref_prio = !win;
        grant_log.push_back(int'(win));
        iss_pend = 1'b1;
        iss_cyc  = cycle + 1;
        iss_req  = r;
        if (r.we) begin
          ref_mem[r.addr] = r.wdata;
          busy_until = cycle + 2;
        end else begin
          busy_until = cycle + 4;
          rd_iss = cycle + 1;
          e.cyc  = cycle + 3;
          e.data = ref_mem[r.addr];
          if (win) exp1.push_back(e);
          else exp0.push_back(e);
        end
      end
      issue_now = iss_pend && (cycle == iss_cyc);
      chk("ram_cs", 32'(ram_cs), 32'(issue_now));
      chk("ram_we", 32'(ram_we), 32'(issue_now && iss_req.we));
      chk("ram_oe", 32'(ram_oe), 32'((cycle == rd_iss) || (cycle == rd_iss + 1)));
      if (issue_now) begin
        chk("ram_addr", 32'(ram_addr), 32'(iss_req.addr));
        if (iss_req.we) chk("ram_data_in", 32'(ram_data_in), 32'(iss_req.wdata));
        iss_pend = 1'b0;
      end
      rv0 = (exp0.size() != 0) && (exp0[0].cyc == cycle);
      rv1 = (exp1.size() != 0) && (exp1[0].cyc == cycle);
      chk("m0_rvalid", 32'(m0.rvalid), 32'(rv0));
      chk("m1_rvalid", 32'(m1.rvalid), 32'(rv1));
      if (rv0) begin
        chk("m0_rdata", 32'(m0.rdata), 32'(exp0[0].data));
        void'(exp0.pop_front());
      end
      if (rv1) begin
        chk("m1_rdata", 32'(m1.rdata), 32'(exp1[0].data));
        void'(exp1.pop_front());
      end
    end
    hold0 = m0.valid && !m0.ready;
    hold1 = m1.valid && !m1.ready;
    @(posedge clk);
    cycle++;
    if (!rst_n) begin
      rst_seen   = 1'b1;
      ref_prio   = 1'b0;
      iss_pend   = 1'b0;
      rd_iss     = -10;
      busy_until = 0;
      exp0.delete();
      exp1.delete();
    end else begin
      rst_seen = 1'b0;
    end
    #1;
    if (g0) void'(pend0.pop_front());
    if (g1) void'(pend1.pop_front());
    drive();
  endtask

  function automatic bit busy();
    return (pend0.size() != 0) || (pend1.size() != 0) || (exp0.size() != 0) ||
           (exp1.size() != 0) || (cycle < busy_until);
  endfunction

  task automatic run(input int max_cyc);
    int n;
    n = 0;
    while (busy() && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain_in_budget", 32'(busy()), 32'd0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0.valid = 1'b0; m0.we = 1'b0; m0.addr = '0; m0.wdata = '0;
    m1.valid = 1'b0; m1.we = 1'b0; m1.addr = '0; m1.wdata = '0;
    rd_iss = -10;

    // Reset with m0 requesting; m1 joins at release and must lose the tie
    pend0.push_back(mk_req(1'b1, 0, 8'h5A));
    drive();
    do_reset(3);
    pend1.push_back(mk_req(1'b1, 1, 8'h3C));
    drive();
    base = grant_log.size();
    run(50);
    chk("first_grant_after_reset", 32'(grant_log[base]), 32'd0);

    // Single write then read on m0
    pend0.push_back(mk_req(1'b1, 5, 8'hA5));
    pend0.push_back(mk_req(1'b0, 5, 0));
    drive();
    run(50);
    chk("m0_rdata_after_rd5", 32'(m0.rdata), 32'hA5);

    // Contention on address 3
    do_reset(2);
    pend0.push_back(mk_req(1'b1, 3, 8'h11));
    pend0.push_back(mk_req(1'b0, 3, 0));
    pend1.push_back(mk_req(1'b1, 3, 8'h22));
    pend1.push_back(mk_req(1'b0, 3, 0));
    drive();
    base = grant_log.size();
    run(60);
    for (int k = 0; k < 4; k++) chk("contention_order", 32'(grant_log[base + k]), 32'(exp_order[k]));
    chk("contention_m0_rdata", 32'(m0.rdata), 32'h22);
    chk("contention_m1_rdata", 32'(m1.rdata), 32'h22);

    // Fill and dump from m1
    for (int i = 0; i < 16; i++) pend1.push_back(mk_req(1'b1, i, i * 3));
    for (int i = 0; i < 16; i++) pend1.push_back(mk_req(1'b0, i, 0));
    drive();
    run(200);
    chk("dump_last_rdata", 32'(m1.rdata), 32'd45);

    // Fairness: continuous reads on both ports
    for (int i = 0; i < 8; i++) begin
      pend0.push_back(mk_req(1'b0, int'($urandom_range(15)), 0));
      pend1.push_back(mk_req(1'b0, int'($urandom_range(15)), 0));
    end
    drive();
    base = grant_log.size();
    run(200);
    chk("fair_grant_count", 32'(grant_log.size() - base), 32'd16);
    for (int k = base + 1; k < base + 16; k++)
      chk("fair_alternate", 32'(grant_log[k] != grant_log[k - 1]), 32'd1);

    // Random mixed traffic with idle gaps
    repeat (400) begin
      if (pend0.size() == 0 && $urandom_range(2) == 0) pend0.push_back(rnd_req());
      if (pend1.size() == 0 && $urandom_range(2) == 0) pend1.push_back(rnd_req());
      drive();
      step();
    end
    run(100);

    // Reset during WAIT aborts the read
    pend0.push_back(mk_req(1'b0, 9, 0));
    drive();
    base = grant_log.size();
    step();
    step();
    chk("midrd_accepted", 32'(grant_log.size() - base), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (4) step();
    pend0.push_back(mk_req(1'b0, 9, 0));
    drive();
    run(50);
    chk("midrd_reread", 32'(m0.rdata), 32'(ref_mem[9]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
